// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter funnelling NREQ writers into one FIFO
//               write port. Optional macro FIFO_WR_ARB_STALL_CNT_EN adds a
//               saturating stall_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int data  = 128,
    parameter int BURST = 4
) (
    input  logic                 w_clk,
    input  logic                 w_rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*data-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      grant,
    output logic                 w_en,
    output logic [data-1:0]      wdata,
    input  logic                 w_full
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(BURST) + 1;
    localparam logic [CNTW-1:0] c_LAST_BEAT = CNTW'(BURST - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDXW-1:0] r_owner;
    logic [IDXW-1:0] w_owner_nxt;
    logic [IDXW-1:0] r_rr_ptr;
    logic [IDXW-1:0] w_rr_ptr_nxt;
    logic [CNTW-1:0] r_beat_cnt;
    logic [CNTW-1:0] w_beat_cnt_nxt;

    logic            w_found;
    logic [IDXW-1:0] w_sel;
    logic [IDXW-1:0] w_sel_next;
    logic            w_own_valid;
    logic            w_xfer;

    // Cyclic search: the k-th candidate is (rr_ptr + k) mod NREQ.
    always_comb begin
        w_found    = 1'b0;
        w_sel      = '0;
        w_sel_next = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && req_valid[i] &&
                    (i == ((int'(r_rr_ptr) + k) % NREQ))) begin
                    w_found    = 1'b1;
                    w_sel      = IDXW'(i);
                    w_sel_next = IDXW'((i + 1) % NREQ);
                end
            end
        end
    end

    always_comb begin
        w_own_valid = 1'b0;
        wdata       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == IDXW'(i)) begin
                w_own_valid = req_valid[i];
                if (r_state == S_BUSY) begin
                    wdata = req_data[i*data +: data];
                end
            end
        end
    end

    assign w_xfer = (r_state == S_BUSY) && w_own_valid && !w_full;
    assign w_en   = w_xfer;

    always_comb begin
        grant     = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if ((r_state == S_BUSY) && (r_owner == IDXW'(i))) begin
                grant[i]     = 1'b1;
                req_ready[i] = w_xfer;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_owner_nxt  = w_sel;
                    w_rr_ptr_nxt = w_sel_next;
                    w_state_nxt  = S_BUSY;
                end
            end
            S_BUSY: begin
                // A dropped valid releases even under w_full; w_full alone only stalls.
                if (!w_own_valid) begin
                    w_state_nxt    = S_IDLE;
                    w_beat_cnt_nxt = '0;
                end else if (w_xfer) begin
                    if (r_beat_cnt == c_LAST_BEAT) begin
                        w_state_nxt    = S_IDLE;
                        w_beat_cnt_nxt = '0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_beat_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_BUSY) && w_own_valid && w_full &&
                     (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    // Stall counter not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed self-checking bench for fifo_wr_arbiter (default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 128;
    localparam int BURST = 4;

    logic                 w_clk;
    logic                 w_rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      grant;
    logic                 w_en;
    logic [DW-1:0]        wdata;
    logic                 w_full;

    int n_vec;
    int n_err;
    int cnt [NREQ];

    fifo_wr_arbiter #(
        .NREQ (NREQ),
        .data (DW),
        .BURST(BURST)
    ) u_dut (
        .w_clk    (w_clk),
        .w_rst_n  (w_rst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .grant    (grant),
        .w_en     (w_en),
        .wdata    (wdata),
        .w_full   (w_full)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Requester i's b-th word carries its index and sequence number.
    function automatic logic [DW-1:0] mk(input int i, input int b);
        return {64'hDEAD_BEEF_0000_0000, 32'(i), 32'(b)};
    endfunction

    task automatic upd();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = mk(i, cnt[i]);
    endtask

    task automatic step();
        @(posedge w_clk);
        #1;
        upd();
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic [NREQ-1:0] g,
                             input logic en, input logic [DW-1:0] d);
        #1;
        chk({tag, "/grant"}, DW'(grant), DW'(g));
        chk({tag, "/ready"}, DW'(req_ready), en ? DW'(g) : DW'(0));
        chk({tag, "/w_en"}, DW'(w_en), DW'(en));
        if (en) chk({tag, "/wdata"}, wdata, d);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        w_rst_n   = 1'b0;
        req_valid = '0;
        w_full    = 1'b0;
        upd();
        repeat (2) @(posedge w_clk);
        #1;
        expect_st("rst", 4'b0000, 1'b0, '0);
        w_rst_n = 1'b1;

        // Single requester 1, six beats: 4-beat burst, idle gap, 2 more beats
        req_valid = 4'b0010;
        expect_st("t1_idle", 4'b0000, 1'b0, '0);
        step();
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                expect_st("t1_gap", 4'b0000, 1'b0, '0);
                step();
            end
            expect_st($sformatf("t1_b%0d", k), 4'b0010, 1'b1, mk(1, k));
            cnt[1]++;
            step();
        end
        req_valid = 4'b0000;
        expect_st("t1_drop", 4'b0010, 1'b0, '0);
        step();
        expect_st("t1_rel", 4'b0000, 1'b0, '0);

        // Fairness after reset: 0,1,2,3,0 with 4 beats and one idle each
        w_rst_n = 1'b0;
        step();
        w_rst_n = 1'b1;
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            expect_st($sformatf("t2_idle%0d", g), 4'b0000, 1'b0, '0);
            step();
            for (int b = 0; b < BURST; b++) begin
                expect_st($sformatf("t2_g%0d_b%0d", g, b), 4'(1 << (g % 4)), 1'b1,
                          mk(g % 4, cnt[g % 4]));
                cnt[g % 4]++;
                step();
            end
        end

        // Owner 2 stalls for 3 cycles mid-burst, others valid but never served
        req_valid = 4'b0100;
        expect_st("t3_idle", 4'b0000, 1'b0, '0);
        step();
        req_valid = 4'b1111;
        for (int b = 0; b < 2; b++) begin
            expect_st($sformatf("t3_b%0d", b), 4'b0100, 1'b1, mk(2, cnt[2]));
            cnt[2]++;
            step();
        end
        w_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            expect_st($sformatf("t3_stall%0d", s), 4'b0100, 1'b0, '0);
            step();
        end
        w_full = 1'b0;
        for (int b = 2; b < 4; b++) begin
            expect_st($sformatf("t3_b%0d", b), 4'b0100, 1'b1, mk(2, cnt[2]));
            cnt[2]++;
            step();
        end
        expect_st("t3_end", 4'b0000, 1'b0, '0);

        // Owner 1 drops after 2 beats; next grant skips to index 3
        req_valid = 4'b0010;
        step();
        for (int b = 0; b < 2; b++) begin
            expect_st($sformatf("t4_b%0d", b), 4'b0010, 1'b1, mk(1, cnt[1]));
            cnt[1]++;
            step();
        end
        req_valid = 4'b1001;
        expect_st("t4_drop", 4'b0010, 1'b0, '0);
        step();
        expect_st("t4_idle", 4'b0000, 1'b0, '0);
        step();
        for (int b = 0; b < 2; b++) begin
            expect_st($sformatf("t4_next_b%0d", b), 4'b1000, 1'b1, mk(3, cnt[3]));
            cnt[3]++;
            step();
        end

        // Reset during the third beat aborts; arbitration restarts at 0
        expect_st("t5_b2", 4'b1000, 1'b1, mk(3, cnt[3]));
        w_rst_n = 1'b0;
        step();
        expect_st("t5_rst", 4'b0000, 1'b0, '0);
        w_rst_n = 1'b1;
        step();
        expect_st("t5_restart", 4'b0001, 1'b1, mk(0, cnt[0]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of write requesters (2..8).
REQ-002 SHALL have parameter data, default 128: FIFO data word width.
REQ-003 SHALL have parameter BURST, default 4: maximum beats per grant (1..16).
REQ-004 SHALL have port w_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port w_rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port req_valid, input, NREQ: bit i means requester i offers a beat.
REQ-007 SHALL have port req_data, input, NREQ*data: requester i's word is slice [i*data +: data].
REQ-008 SHALL have port req_ready, output, NREQ: bit i means requester i's beat is accepted this cycle.
REQ-009 SHALL have port grant, output, NREQ: one-hot current owner; all zero when not BUSY.
REQ-010 SHALL have port w_en, output, 1: FIFO write enable.
REQ-011 SHALL have port wdata, output, data: FIFO write data.
REQ-012 SHALL have port w_full, input, 1: FIFO write-domain full flag.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-014 In IDLE with any req_valid bit high: SHALL select the first valid index at or after rr_ptr (cyclic), register it as owner, set rr_ptr to owner+1 (mod NREQ) and move to BUSY next cycle. No transfer occurs in IDLE.
REQ-015 In IDLE with req_valid all zero: SHALL stay in IDLE with rr_ptr unchanged.
REQ-016 In BUSY, outputs SHALL be combinational: req_ready[owner] = req_valid[owner] & ~w_full; w_en = the same term; wdata = owner's slice; all other req_ready bits 0.
REQ-017 A beat SHALL transfer exactly when req_valid[i] & req_ready[i]; beat_cnt (width clog2(BURST)+1) then increments by 1.
REQ-018 BUSY -> IDLE SHALL occur after the beat that makes beat_cnt equal BURST, or on any cycle in BUSY where req_valid[owner] is 0; beat_cnt clears to 0 on that transition.
REQ-019 When w_full is high in BUSY: SHALL hold owner, beat_cnt and state, with w_en 0 (stall, no release).
REQ-020 w_en SHALL never be 1 while w_full is 1 or while in IDLE.
REQ-021 Requesters other than owner SHALL see req_ready 0 even if valid; their data is never routed.
REQ-022 Fairness: with all requesters continuously valid, grants SHALL rotate 0,1,..,NREQ-1,0 with BURST beats each and one IDLE cycle between grants.

Reset
REQ-023 With w_rst_n low at a w_clk edge: state IDLE, owner 0, rr_ptr 0, beat_cnt 0; hence grant, req_ready and w_en are 0.
REQ-024 Reset asserted mid-burst SHALL abort the burst; no w_en on the cycle after the reset edge; beats already written are not recalled.

Configuration
REQ-025 With macro FIFO_WR_ARB_STALL_CNT_EN defined: SHALL add output stall_cnt, 16 bits. It increments on each cycle in BUSY where req_valid[owner] & w_full, saturates at 16'hFFFF, and clears on reset.
REQ-026 Without FIFO_WR_ARB_STALL_CNT_EN: the stall_cnt port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Single requester: req_valid=4'b0010 for 6 beats (BURST=4), w_full=0 -> IDLE 1 cycle, then 4 writes with grant=4'b0010, then IDLE 1 cycle, then 2 writes; 6 w_en pulses total with data in order.
REQ-028 All four valid continuously -> grant sequence 0001,0010,0100,1000,0001, each held 4 beats, 1 idle cycle between grants.
REQ-029 Owner 2 mid-burst, w_full=1 for 3 cycles -> w_en=0 and req_ready=0 for 3 cycles, grant stays 4'b0100, burst resumes, and 4 beats total are delivered.
REQ-030 Owner 1 drops req_valid after 2 beats -> return to IDLE next cycle; next grant goes to the next valid index after 1.
REQ-031 w_rst_n=0 during beat 2 of a burst -> the next cycle has grant=0 and w_en=0; after release, arbitration restarts from index 0.
REQ-032 With FIFO_WR_ARB_STALL_CNT_EN: hold w_full=1 for 70000 cycles while the owner is valid -> stall_cnt=16'hFFFF and holds there; reset -> 0.
